scroll_sched: RTL
=================

SCROLL_SCHED -- requirements
Module: scroll_sched

Interface
REQ-001 SHALL provide parameter TICK_BITS, default 24, meaning the base step period is 2^TICK_BITS clock cycles.
REQ-002 SHALL provide parameter MSG_LEN, default 8, meaning the number of scroll positions (range 2..8).
REQ-003 SHALL provide port CLOCK_50, input, 1 bit: the single system clock; all logic uses its rising edge.
REQ-004 SHALL provide port KEY, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port run, input, 1 bit: level request to scroll.
REQ-006 SHALL provide port freeze, input, 1 bit: level request to hold the display and the prescaler.
REQ-007 SHALL provide port dir, input, 1 bit: scroll direction; 0 increments, 1 decrements.
REQ-008 SHALL provide port speed, input, 2 bits: step period selector.
REQ-009 SHALL provide port pos, output, 3 bits: current rotation offset for the display datapath.
REQ-010 SHALL provide port step, output, 1 bit: one-cycle pulse in the cycle that pos changes.
REQ-011 SHALL provide port busy, output, 1 bit: high in the RUN, HOMING and FROZEN states.

Function
REQ-012 SHALL implement an FSM with the states IDLE, RUN, HOMING and FROZEN.
REQ-013 Transitions from IDLE SHALL be: to RUN when run=1 and freeze=0; otherwise stay in IDLE.
REQ-014 Transitions from RUN SHALL be:
- to FROZEN if freeze=1 (takes priority);
- else to HOMING if run=0.
REQ-015 Transitions from HOMING SHALL be:
- to FROZEN if freeze=1;
- else to RUN if run=1;
- else to IDLE in the cycle after a step that makes pos=0;
- directly to IDLE on entry if pos is already 0.
REQ-016 FROZEN SHALL return to the state it came from (RUN or HOMING) when freeze=0.
REQ-017 In FROZEN, pos and the prescaler SHALL hold their values.
REQ-018 The prescaler SHALL count 0..LIMIT, where LIMIT = (2^TICK_BITS >> speed) - 1, only in RUN and HOMING.
REQ-019 When the prescaler equals LIMIT, it SHALL wrap to 0 and issue a step in the same cycle.
REQ-020 speed SHALL be sampled only when the prescaler wraps or on entry to RUN from IDLE; mid-period changes take effect at the next period.
REQ-021 On a step, pos SHALL become (pos+1) mod MSG_LEN if dir=0, and (pos-1) mod MSG_LEN if dir=1:
- MSG_LEN-1 steps up to 0;
- 0 steps down to MSG_LEN-1.
REQ-022 dir SHALL be sampled in the step cycle.
REQ-023 In HOMING, the scroll direction SHALL be forced to the shortest path to 0, with ties going up.
REQ-024 step SHALL be registered and SHALL be high in exactly the cycle that the new pos value appears.
REQ-025 Leaving IDLE for RUN SHALL clear the prescaler, so the first step occurs LIMIT+1 cycles after entry.
REQ-026 If run and freeze rise in the same cycle while in IDLE, the block SHALL stay in IDLE.
REQ-027 pos SHALL always lie in 0..MSG_LEN-1.

Reset
REQ-028 While KEY=0, the block SHALL be in IDLE with pos=0, step=0, busy=0, prescaler=0 and latched speed=0, regardless of the clock.
REQ-029 Reset asserted mid-RUN or mid-HOMING SHALL abort immediately.
REQ-030 After KEY rises, the first state change SHALL occur on the first rising clock edge.

Structure
REQ-031 A shared package SHALL hold the FSM state enum type and the direction encoding constants (UP=0, DOWN=1).
REQ-032 The prescaler SHALL be a separate sub-module, tick_gen, with ports clock, reset, enable, clear, speed and tick; the FSM and pos register SHALL stay in scroll_sched.

Verification (bench parameters TICK_BITS=4, MSG_LEN=8)
REQ-033 Release reset, then run=1, speed=0, dir=0 -> step every 16 cycles; pos sequence 1,2,...,7,0,1.
REQ-034 Set speed=2 mid-period -> the current period finishes at 16 cycles; later steps occur every 4 cycles.
REQ-035 With pos=5, drop run -> HOMING steps up 6,7,0, then IDLE with busy=0 and no further steps.
REQ-036 With pos=2, drop run -> HOMING steps down 1,0, then IDLE.
REQ-037 Assert freeze for 10 cycles at prescaler=7 -> pos and prescaler hold; after release, the next step comes 9 cycles later.
REQ-038 Pull KEY low mid-RUN at pos=6, between clock edges -> pos=0, step=0, busy=0 asynchronously; hold run=1 -> restart from pos 0, first step 16 cycles after KEY rises.

Source files
------------

// File: rtl/scroll_sched_pkg.sv
// Shared types and constants for the scroll scheduler.
package scroll_sched_pkg;

    localparam int unsigned POS_W   = 3;
    localparam int unsigned SPEED_W = 2;

    // Scroll direction encoding
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOMING = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    // Next rotation offset, wrapping modulo (last+1)
    function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] p,
                                                  input logic             d,
                                                  input logic [POS_W-1:0] last);
        logic [POS_W-1:0] r;
        if (d == DIR_UP) begin
            r = (p == last) ? POS_W'(0) : p + POS_W'(1);
        end else begin
            r = (p == POS_W'(0)) ? last : p - POS_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/scroll_sched_tick_gen.sv
// Step prescaler: counts 0..LIMIT while enabled, LIMIT = (2^TICK_BITS >> speed) - 1.
module tick_gen
    import scroll_sched_pkg::*;
#(
    parameter int unsigned TICK_BITS = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [TICK_BITS-1:0] cnt;
    logic [SPEED_W-1:0]   spd;
    logic [TICK_BITS-1:0] limit;

    // All-ones shifted right equals 2^(TICK_BITS-spd) - 1
    assign limit = {TICK_BITS{1'b1}} >> spd;
    assign tick  = enable && (cnt == limit);

    // Counter and latched speed; speed is only picked up at a wrap or a clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            spd <= '0;
        end else if (clear) begin
            cnt <= '0;
            spd <= speed;
        end else if (enable) begin
            if (cnt == limit) begin
                cnt <= '0;
                spd <= speed;
            end else begin
                cnt <= cnt + TICK_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/scroll_sched.sv
// Scroll scheduler: run/home/freeze FSM driving a rotation offset for a display.
module scroll_sched
    import scroll_sched_pkg::*;
#(
    parameter int unsigned TICK_BITS = 24,
    parameter int unsigned MSG_LEN   = 8
) (
    input  logic               CLOCK_50,
    input  logic               KEY,
    input  logic               run,
    input  logic               freeze,
    input  logic               dir,
    input  logic [SPEED_W-1:0] speed,
    output logic [POS_W-1:0]   pos,
    output logic               step,
    output logic               busy
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);
    localparam int unsigned      CMP_W    = POS_W + 2;

    state_t           state;
    state_t           state_nxt;
    state_t           ret_state;
    state_t           ret_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             step_nxt;
    logic             busy_nxt;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;
    logic             home_dir;
    logic             step_dir;

    // Shortest way back to 0; a tie (pos == MSG_LEN/2) goes up
    assign home_dir = ((CMP_W'(pos) << 1) < CMP_W'(MSG_LEN)) ? DIR_DOWN : DIR_UP;
    assign step_dir = (state == ST_HOMING) ? home_dir : dir;

    assign tick_en  = (state == ST_RUN) || (state == ST_HOMING);
    assign tick_clr = (state == ST_IDLE) && (state_nxt == ST_RUN);

    tick_gen #(
        .TICK_BITS (TICK_BITS)
    ) u_tick (
        .clock  (CLOCK_50),
        .reset  (KEY),
        .enable (tick_en),
        .clear  (tick_clr),
        .speed  (speed),
        .tick   (tick)
    );

    // State, return state and registered outputs
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state     <= ST_IDLE;
            ret_state <= ST_RUN;
            pos       <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            pos       <= pos_nxt;
            step      <= step_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        pos_nxt   = pos;
        step_nxt  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (run && !freeze) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (freeze) begin
                    state_nxt = ST_FROZEN;
                    ret_nxt   = ST_RUN;
                end else if (!run) begin
                    state_nxt = ST_HOMING;
                end
            end
            ST_HOMING: begin
                if (freeze) begin
                    state_nxt = ST_FROZEN;
                    ret_nxt   = ST_HOMING;
                end else if (run) begin
                    state_nxt = ST_RUN;
                end else if (pos == POS_W'(0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_nxt = ret_state;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A tick moves pos unless homing has already reached 0 and is leaving
        if (tick && (state_nxt != ST_IDLE)) begin
            pos_nxt  = pos_next(pos, step_dir, POS_LAST);
            step_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
